// File: rtl/acq_stream_packer.sv
// Merges CH_NUM valid/ready sample streams into framed packets: header, SETS_PER_PKT channel-ordered sets, m_last on final word.
// Optional trailer checksum word enabled by defining ACQ_PACK_CHECKSUM_EN.
module acq_stream_packer #(
    parameter int          CH_NUM       = 4,
    parameter int          DW           = 32,
    parameter int          SETS_PER_PKT = 16,
    parameter logic [15:0] HDR_MAGIC    = 16'hA5C3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CH_NUM*DW-1:0] in_data,
    input  logic [CH_NUM-1:0]    in_valid,
    output logic [CH_NUM-1:0]    in_ready,
    output logic [DW-1:0]        m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [7:0]           pkt_seq,
    output logic                 busy
);

    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CKSUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     ch_r, ch_s;
    logic [15:0]       set_r, set_s;
    logic [DW-1:0]     m_data_r, data_s;
    logic              m_valid_r, valid_s;
    logic              m_last_r, last_s;
    logic [7:0]        pkt_seq_r, seq_s;
    logic              busy_r, busy_s;
    logic              load_s;
    logic              final_s;
    logic [DW-1:0]     hdr_s;
    logic [DW-1:0]     sel_data_s;
    logic              sel_valid_s;
    logic [CH_NUM-1:0] in_ready_s;
`ifdef ACQ_PACK_CHECKSUM_EN
    logic [DW-1:0]     cksum_r, cksum_s;
`endif

    assign load_s  = !m_valid_r || m_ready;
    assign final_s = (ch_r == CW'(CH_NUM - 1)) && (set_r == 16'(SETS_PER_PKT - 1));
    assign hdr_s   = DW'({HDR_MAGIC, 8'(CH_NUM), pkt_seq_r});

    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;
    assign m_last   = m_last_r;
    assign pkt_seq  = pkt_seq_r;
    assign busy     = busy_r;
    assign in_ready = in_ready_s;

    // Select the current channel and grant only it while in DATA and the output stage can load
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        in_ready_s  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            sel_data_s    = (ch_r == CW'(c)) ? in_data[c*DW +: DW] : sel_data_s;
            sel_valid_s   = (ch_r == CW'(c)) ? in_valid[c] : sel_valid_s;
            in_ready_s[c] = (ch_r == CW'(c)) && (state_r == ST_DATA) && load_s;
        end
    end

    // Next-state and next-register values for the packet sequencer and output stage
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        set_s   = set_r;
        data_s  = m_data_r;
        valid_s = m_valid_r && !m_ready;
        last_s  = m_last_r;
        seq_s   = pkt_seq_r;
`ifdef ACQ_PACK_CHECKSUM_EN
        cksum_s = cksum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (en && load_s) begin
                    data_s  = hdr_s;
                    valid_s = 1'b1;
                    last_s  = 1'b0;
                    ch_s    = '0;
                    set_s   = 16'd0;
`ifdef ACQ_PACK_CHECKSUM_EN
                    cksum_s = '0;
`endif
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (sel_valid_s && load_s) begin
                    data_s  = sel_data_s;
                    valid_s = 1'b1;
                    last_s  = 1'b0;
`ifdef ACQ_PACK_CHECKSUM_EN
                    cksum_s = cksum_r + sel_data_s;
`endif
                    if (final_s) begin
`ifdef ACQ_PACK_CHECKSUM_EN
                        state_s = ST_CKSUM;
`else
                        last_s  = 1'b1;
                        state_s = ST_DONE;
`endif
                    end else if (ch_r == CW'(CH_NUM - 1)) begin
                        ch_s  = '0;
                        set_s = set_r + 16'd1;
                    end else begin
                        ch_s = ch_r + CW'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef ACQ_PACK_CHECKSUM_EN
            ST_CKSUM: begin
                if (load_s) begin
                    data_s  = cksum_r;
                    valid_s = 1'b1;
                    last_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CKSUM;
                end
            end
`endif
            ST_DONE: begin
                if (m_valid_r && m_ready && m_last_r) begin
                    seq_s   = pkt_seq_r + 8'd1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ch_r      <= '0;
            set_r     <= 16'd0;
            m_data_r  <= '0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            pkt_seq_r <= 8'd0;
            busy_r    <= 1'b0;
`ifdef ACQ_PACK_CHECKSUM_EN
            cksum_r   <= '0;
`endif
        end else begin
            state_r   <= state_s;
            ch_r      <= ch_s;
            set_r     <= set_s;
            m_data_r  <= data_s;
            m_valid_r <= valid_s;
            m_last_r  <= last_s;
            pkt_seq_r <= seq_s;
            busy_r    <= busy_s;
`ifdef ACQ_PACK_CHECKSUM_EN
            cksum_r   <= cksum_s;
`endif
        end
    end

endmodule

// File: tb/tb_acq_stream_packer.sv
// Directed self-checking bench for acq_stream_packer (CH_NUM=4, SETS_PER_PKT=2); honours ACQ_PACK_CHECKSUM_EN.
module tb_acq_stream_packer;

    localparam int CH   = 4;
    localparam int DW   = 32;
    localparam int SETS = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CH*DW-1:0] in_data;
    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    in_ready;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [7:0]       pkt_seq;
    logic             busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt[CH];
    logic [31:0] got_d[$];
    bit          got_l[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    bit          last_seen;
    logic        o_valid, o_last, o_busy;
    logic [31:0] o_data;
    logic [CH-1:0] o_ready;
    logic [7:0]  o_seq;

    acq_stream_packer #(.CH_NUM(CH), .DW(DW), .SETS_PER_PKT(SETS), .HDR_MAGIC(16'hA5C3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .pkt_seq(pkt_seq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive_data();
        for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 32'(256 * c + cnt[c]);
    endtask

    // Sample at negedge, log output handshakes, advance channel sources, then re-drive after posedge
    task automatic step();
        @(negedge clk);
        o_valid = m_valid; o_last = m_last; o_data = m_data;
        o_ready = in_ready; o_seq = pkt_seq; o_busy = busy;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            if (m_last) last_seen = 1'b1;
        end
        for (int c = 0; c < CH; c++) if (in_valid[c] && in_ready[c]) cnt[c]++;
        @(posedge clk);
        #1;
        drive_data();
    endtask

    task automatic clear_got();
        got_d.delete(); got_l.delete(); last_seen = 1'b0;
    endtask

    task automatic build_exp(input logic [7:0] seq);
        logic [31:0] sum;
        logic [31:0] w;
        bit          fin;
        exp_d.delete(); exp_l.delete(); sum = 32'd0;
        exp_d.push_back({16'hA5C3, 8'h04, seq}); exp_l.push_back(1'b0);
        for (int s = 0; s < SETS; s++) begin
            for (int c = 0; c < CH; c++) begin
                w = 32'(256 * c + s);
                sum = sum + w;
`ifdef ACQ_PACK_CHECKSUM_EN
                fin = 1'b0;
`else
                fin = (s == SETS - 1) && (c == CH - 1);
`endif
                exp_d.push_back(w); exp_l.push_back(fin);
            end
        end
`ifdef ACQ_PACK_CHECKSUM_EN
        exp_d.push_back(sum); exp_l.push_back(1'b1);
`endif
    endtask

    task automatic run_pkt(input int budget);
        clear_got();
        for (int i = 0; i < budget && !last_seen; i++) step();
        n_checks++;
        if (!last_seen) begin
            n_fail++;
            $display("FAIL pkt_timeout: no last word within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b1; in_valid = '0;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        drive_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; in_valid = '1;
        #1;
        n_checks += 6;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
        if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got %b exp 0", m_last); end
        if (m_data !== 32'd0) begin n_fail++; $display("FAIL rst_m_data got %h exp 0", m_data); end
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0000", in_ready); end
        if (pkt_seq !== 8'd0) begin n_fail++; $display("FAIL rst_pkt_seq got %0d exp 0", pkt_seq); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = '1; en = 1'b1;
        build_exp(8'd0);
        run_pkt(60);
        en = 1'b0;
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL basic_len got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                n_fail++; $display("FAIL basic_word[%0d] got %h/%0b exp %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        n_checks++;
        if (got_d.size() > 0 && got_d[0] !== 32'hA5C3_0400) begin n_fail++; $display("FAIL basic_header got %h exp a5c30400", got_d[0]); end
`ifdef ACQ_PACK_CHECKSUM_EN
        n_checks++;
        if (got_d.size() != 10 || got_d[9] !== 32'h0000_0C04 || got_l[9] !== 1'b1 || got_d[8] !== 32'h0000_0301) begin
            n_fail++; $display("FAIL cksum_trailer got size %0d exp trailer 00000c04 last after 00000301", got_d.size());
        end
`endif
        step();
        n_checks += 2;
        if (o_seq !== 8'd1) begin n_fail++; $display("FAIL basic_seq got %0d exp 1", o_seq); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b exp 0", o_busy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_d;
        logic        hold_l;
        bit          stalled;
        do_reset();
        in_valid = '1; en = 1'b1; stalled = 1'b0;
        build_exp(8'd0);
        clear_got();
        for (int i = 0; i < 80 && !last_seen; i++) begin
            step();
            if (!stalled && got_d.size() == 4) begin
                stalled = 1'b1;
                m_ready = 1'b0;
                step();
                hold_d = o_data; hold_l = o_last;
                n_checks += 3;
                if (hold_d !== 32'h0000_0300) begin n_fail++; $display("FAIL bp_word got %h exp 00000300", hold_d); end
                if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", o_valid); end
                if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0000", o_ready); end
                for (int k = 0; k < 2; k++) begin
                    step();
                    n_checks += 3;
                    if (o_data !== hold_d || o_last !== hold_l) begin
                        n_fail++; $display("FAIL bp_hold got %h/%0b exp %h/%0b", o_data, o_last, hold_d, hold_l);
                    end
                    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", o_valid); end
                    if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0000", o_ready); end
                end
                m_ready = 1'b1;
            end
        end
        en = 1'b0;
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL bp_len got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                n_fail++; $display("FAIL bp_word[%0d] got %h/%0b exp %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_channel_stall();
        bit seen;
        do_reset();
        in_valid = 4'b1011; en = 1'b1; seen = 1'b0;
        build_exp(8'd0);
        clear_got();
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (o_ready === 4'b0100) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stall_reach got in_ready %b exp 0100", o_ready); end
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks += 2;
            if (o_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_in_ready got %b exp 0100", o_ready); end
            if (cnt[3] != 0) begin n_fail++; $display("FAIL stall_ch3_early got %0d exp 0", cnt[3]); end
        end
        in_valid = 4'b1111;
        for (int i = 0; i < 60 && !last_seen; i++) step();
        en = 1'b0;
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL stall_len got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                n_fail++; $display("FAIL stall_word[%0d] got %h/%0b exp %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        in_valid = '1; en = 1'b1;
        for (int p = 0; p < 257; p++) begin
            for (int c = 0; c < CH; c++) cnt[c] = 0;
            drive_data();
            run_pkt(40);
            n_checks++;
            if (got_d.size() == 0 || got_d[0][7:0] !== 8'(p)) begin
                n_fail++; $display("FAIL wrap_seq pkt %0d got %h exp seq %0d", p, (got_d.size() > 0) ? got_d[0] : 32'hx, p % 256);
            end
            if (p == 256) begin
                n_checks++;
                if (got_d.size() == 0 || got_d[0] !== 32'hA5C3_0400) begin n_fail++; $display("FAIL wrap_257th_header got %h exp a5c30400", (got_d.size() > 0) ? got_d[0] : 32'hx); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_enable();
        do_reset();
        in_valid = '1; en = 1'b1;
        run_pkt(60);
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        drive_data();
        clear_got();
        for (int i = 0; i < 40 && got_d.size() < 6; i++) step();
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_m_valid got %b exp 0", m_valid); end
        if (m_data !== 32'd0) begin n_fail++; $display("FAIL arst_m_data got %h exp 0", m_data); end
        if (pkt_seq !== 8'd0) begin n_fail++; $display("FAIL arst_pkt_seq got %0d exp 0", pkt_seq); end
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL arst_in_ready got %b exp 0000", in_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy); end
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        drive_data();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build_exp(8'd0);
        run_pkt(60);
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL arst_len got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                n_fail++; $display("FAIL arst_word[%0d] got %h/%0b exp %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        drive_data();
        build_exp(8'd1);
        clear_got();
        for (int i = 0; i < 60 && !last_seen; i++) begin
            step();
            if (got_d.size() >= 1) en = 1'b0;
        end
        n_checks++;
        if (got_d.size() !== exp_d.size()) begin n_fail++; $display("FAIL en_drop_len got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                n_fail++; $display("FAIL en_drop_word[%0d] got %h/%0b exp %h/%0b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks += 2;
            if (o_busy !== 1'b0) begin n_fail++; $display("FAIL en_off_busy got %b exp 0", o_busy); end
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL en_off_valid got %b exp 0", o_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b1; in_valid = '0; in_data = '0;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        last_seen = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_channel_stall();
        test_seq_wrap();
        test_reset_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
